switch_pulse_seq: RTL and testbench
===================================

// Module: switch_pulse_seq
// PURPOSE
//  Upstream sequencer for the photonic-switch RS flip-flop stage. Converts an async trigger into a
//  timed set pulse (sw_set), programmable hold gap, then reset pulse (sw_rst); the pair drives the
//  downstream S/R inputs. One clock domain; all timing in clk cycles.
// PARAMETERS
//  CNT_W        16  width of delay/width/hold config words and internal down-counter
//  SYNC_STAGES  2   trigger synchroniser depth (>=2)
//  MISS_W       8   miss-counter width (used only with SWITCH_SEQ_MISS_CNT_EN)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  trig         in   1      async trigger; rising edge starts a sequence
//  abort        in   1      sync; terminates an active sequence safely (ends with R pulse)
//  cfg_delay    in   CNT_W  cycles from sequence start to sw_set rise (0 allowed)
//  cfg_width    in   CNT_W  pulse length of sw_set and sw_rst (0 treated as 1)
//  cfg_hold     in   CNT_W  low cycles between sw_set fall and sw_rst rise (0 treated as 1)
//  sw_set       out  1      set pulse to RS stage S input
//  sw_rst       out  1      reset pulse to RS stage R input
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-cycle pulse on return to IDLE
//  miss_clr     in   1      (macro only) sync clear of miss_cnt
//  miss_cnt     out  MISS_W (macro only) triggers ignored while busy, saturating
// BEHAVIOUR
//  - Reset (reset_n low, async): all outputs 0, FSM IDLE, sync chain and counter cleared. Mid-
//    sequence reset drops sw_set/sw_rst immediately; no R pulse is emitted.
//  - trig passes SYNC_STAGES flops; rise = last stage high & previous-sample low, registered.
//  - Edge 0 = first clk edge sampling trig high. FSM leaves IDLE at edge SYNC_STAGES+1; cfg_*
//    captured at that edge and held for the whole sequence (later cfg changes ignored).
//  - States: IDLE -> DLY (cfg_delay cycles; skipped if 0) -> SET (sw_set=1, width cycles) ->
//    HOLD (both low, hold cycles) -> RST (sw_rst=1, width cycles) -> IDLE.
//  - sw_set rises at edge SYNC_STAGES+1+cfg_delay. sw_set and sw_rst never high together;
//    at least one cycle with both low between them.
//  - done=1 for exactly the cycle after RST ends (coincides with busy falling); busy low same edge.
//  - Trigger rise while busy: ignored (no queueing). Rise in cycle busy falls: ignored.
//  - abort (sampled only when busy): DLY -> IDLE, no pulses, done pulses. SET -> sw_set drops
//    next edge, one HOLD cycle, then full RST. HOLD -> RST next edge. RST: ignored, completes.
//    abort in IDLE: no effect; abort together with trigger rise in IDLE: trigger starts.
//  - Counter is CNT_W bits, loads value-1, counts down to 0; cfg max (2^CNT_W-1) is valid.
// CONFIGURATION
//  SWITCH_SEQ_MISS_CNT_EN defined: miss_clr/miss_cnt ports exist; miss_cnt increments on each
//    trigger rise ignored while busy, saturates at 2^MISS_W-1, miss_clr has priority over inc,
//    reset value 0.
//  Not defined: ports and counter absent; ignored triggers are silently dropped.
// TESTING
//  1 Basic: SYNC=2, delay=3, width=2, hold=5, trig rise sampled edge 0 -> busy rises edge 3,
//    sw_set high edges 6-7, sw_rst high edges 13-14, done pulse + busy low at edge 15.
//  2 Zero cfg: delay=0, width=0, hold=0 -> sw_set 1 cycle from edge 3, 1 gap cycle,
//    sw_rst 1 cycle from edge 5, done at edge 6.
//  3 Abort: abort during DLY -> no pulses, done next cycle; abort during SET cycle 1 of width=4
//    -> sw_set falls next edge, 1 low cycle, sw_rst 4 cycles; abort in RST -> no change.
//  4 Retrigger: second trig rise mid-HOLD -> no extra pulses; with macro miss_cnt=1; 300
//    ignored triggers with MISS_W=8 -> miss_cnt=255; miss_clr -> 0.
//  5 Reset mid-SET: reset_n low -> sw_set=0 without clock, busy=0; after release next trig
//    gives normal sequence with cfg re-captured.
//  6 Cfg change during sequence (hold 5->1 in DLY) -> sequence uses captured hold=5.

Source files
------------

// File: rtl/switch_pulse_seq.sv
// rtl/switch_pulse_seq.sv - trigger-to-set/hold/reset pulse sequencer for the photonic RS switch stage
// Optional miss counter of ignored triggers: define SWITCH_SEQ_MISS_CNT_EN.
module switch_pulse_seq #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_hold,
    output logic             sw_set,
    output logic             sw_rst,
    output logic             busy,
    output logic             done
`ifdef SWITCH_SEQ_MISS_CNT_EN
    ,
    input  logic             miss_clr,
    output logic [MISS_W-1:0] miss_cnt
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DLY  = 3'd1;
    localparam logic [2:0] ST_SET  = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_RST  = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   rise_q;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_m1_q, hold_m1_q;
    logic             capture;
    logic             done_d, done_q;

    // Zero-length width/hold behave as one cycle, so both map to a reload of 0.
    function automatic logic [CNT_W-1:0] minus_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], trig};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            rise_q      <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    capture = 1'b1;
                    if (cfg_delay != '0) begin
                        state_d = ST_DLY;
                        cnt_d   = cfg_delay - CNT_W'(1);
                    end else begin
                        state_d = ST_SET;
                        cnt_d   = minus_one(cfg_width);
                    end
                end
            end
            ST_DLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_SET;
                    cnt_d   = width_m1_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SET: begin
                // Aborted set still leaves one both-low cycle before the reset pulse.
                if (abort) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_m1_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (abort || cnt_q == '0) begin
                    state_d = ST_RST;
                    cnt_d   = width_m1_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            width_m1_q <= '0;
            hold_m1_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (capture) begin
                width_m1_q <= minus_one(cfg_width);
                hold_m1_q  <= minus_one(cfg_hold);
            end
        end
    end

    assign sw_set = (state_q == ST_SET);
    assign sw_rst = (state_q == ST_RST);
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

`ifdef SWITCH_SEQ_MISS_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt <= '0;
        end else if (miss_clr) begin
            miss_cnt <= '0;
        end else if (rise_q && state_q != ST_IDLE && miss_cnt != {MISS_W{1'b1}}) begin
            miss_cnt <= miss_cnt + MISS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_switch_pulse_seq.sv
// tb/tb_switch_pulse_seq.sv - randomized bench for switch_pulse_seq against an interval-based timing model
module tb_switch_pulse_seq;
    localparam int CNT_W  = 16;
    localparam int SYNC   = 2;
    localparam int MISS_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             trig;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_hold;
    logic             sw_set, sw_rst, busy, done;
    logic             miss_clr;
`ifdef SWITCH_SEQ_MISS_CNT_EN
    logic [MISS_W-1:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    switch_pulse_seq #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MISS_W(MISS_W)) dut (
        .clk(clk), .reset_n(reset_n), .trig(trig), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_hold(cfg_hold),
        .sw_set(sw_set), .sw_rst(sw_rst), .busy(busy), .done(done)
`ifdef SWITCH_SEQ_MISS_CNT_EN
        , .miss_clr(miss_clr), .miss_cnt(miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: a sequence is a set of edge intervals; an output is high after edge k when k lies in its interval.
    longint k;
    longint m_start, m_set_rise, m_set_fall, m_rst_rise, m_end, m_w;
    longint pend[$];
    bit     m_prev;
    int     m_miss;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, k, actual, expected);
        end
    endtask

    task automatic model_clear();
        m_start = -100; m_set_rise = -100; m_set_fall = -100;
        m_rst_rise = -100; m_end = -100; m_w = 1;
        pend.delete();
        m_prev = 1'b0;
        m_miss = 0;
    endtask

    task automatic model_edge();
        bit busy_before, ignored;
        longint d, w, h;
        k++;
        busy_before = (m_start <= k - 1) && (k - 1 < m_end);
        ignored = 1'b0;
        if (abort && busy_before) begin
            if (k - 1 < m_set_rise) begin
                m_set_rise = k; m_set_fall = k; m_rst_rise = k; m_end = k;
            end else if (k - 1 < m_set_fall) begin
                m_set_fall = k; m_rst_rise = k + 1; m_end = k + 1 + m_w;
            end else if (k - 1 < m_rst_rise) begin
                m_rst_rise = k; m_end = k + m_w;
            end
        end
        if (pend.size() > 0 && pend[0] == k) begin
            void'(pend.pop_front());
            if (busy_before) begin
                ignored = 1'b1;
            end else begin
                d = cfg_delay;
                w = (cfg_width == 0) ? 1 : cfg_width;
                h = (cfg_hold == 0) ? 1 : cfg_hold;
                m_start    = k;
                m_set_rise = k + d;
                m_set_fall = m_set_rise + w;
                m_rst_rise = m_set_fall + h;
                m_end      = m_rst_rise + w;
                m_w        = w;
            end
        end
        if (miss_clr) m_miss = 0;
        else if (ignored && m_miss < 255) m_miss++;
        if (trig && !m_prev) pend.push_back(k + SYNC + 1);
        m_prev = trig;
    endtask

    task automatic compare();
        check("sw_set", sw_set, (m_set_rise <= k && k < m_set_fall));
        check("sw_rst", sw_rst, (m_rst_rise <= k && k < m_end));
        check("busy", busy, (m_start <= k && k < m_end));
        check("done", done, (k == m_end));
`ifdef SWITCH_SEQ_MISS_CNT_EN
        check("miss_cnt", miss_cnt, m_miss);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_trig();
        trig = 1'b1; cycle(); cycle();
        trig = 1'b0; cycle();
    endtask

    task automatic set_cfg(input int d, input int w, input int h);
        cfg_delay = CNT_W'(d); cfg_width = CNT_W'(w); cfg_hold = CNT_W'(h);
    endtask

    // phase: 0 = set rise, 1 = hold start, 2 = rst rise, 3 = back idle
    task automatic run_until(input int phase, input string tag);
        longint target;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            case (phase)
                0: target = m_set_rise;
                1: target = m_set_fall;
                2: target = m_rst_rise;
                default: target = m_end;
            endcase
            if (k == target && m_start >= 0) begin
                hit = 1'b1;
                break;
            end
            cycle();
        end
        check(tag, hit, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        trig = 1'b0; abort = 1'b0; miss_clr = 1'b0;
        #1;
        check("rst_sw_set", sw_set, 1'b0);
        check("rst_sw_rst", sw_rst, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        k = 0;
        model_clear();
        reset_n = 1'b0; trig = 1'b0; abort = 1'b0; miss_clr = 1'b0;
        set_cfg(3, 2, 5);
        #1;
        check("init_sw_set", sw_set, 1'b0);
        check("init_busy", busy, 1'b0);
        check("init_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(3);

        // basic and zero-config sequences
        pulse_trig(); run(20);
        set_cfg(0, 0, 0); pulse_trig(); run(10);

        // abort in delay, in first set cycle, in reset pulse
        set_cfg(6, 3, 3); pulse_trig(); cycle();
        abort = 1'b1; cycle(); abort = 1'b0; run(10);
        set_cfg(2, 4, 6); pulse_trig(); run_until(0, "reach_set");
        abort = 1'b1; cycle(); abort = 1'b0; run(12);
        set_cfg(1, 3, 2); pulse_trig(); run_until(2, "reach_rst");
        abort = 1'b1; cycle(); abort = 1'b0; run(8);
        set_cfg(2, 2, 4); pulse_trig(); run_until(1, "reach_hold");
        abort = 1'b1; cycle(); abort = 1'b0; run(10);

        // abort with trigger at the start edge in idle
        set_cfg(2, 2, 2); trig = 1'b1; cycle(); trig = 1'b0; cycle();
        abort = 1'b1; cycle(); abort = 1'b0; run(12);

        // retrigger while busy, then saturation of the miss counter
        miss_clr = 1'b1; cycle(); miss_clr = 1'b0;
        set_cfg(1, 2, 30); pulse_trig(); run_until(1, "reach_hold2");
        pulse_trig(); run_until(3, "retrig_end"); run(8);
        set_cfg(0, 1, 1000); pulse_trig(); run_until(1, "reach_hold3");
        for (int i = 0; i < 300; i++) begin
            trig = 1'b1; cycle(); trig = 1'b0; cycle();
        end
        run(4);
`ifdef SWITCH_SEQ_MISS_CNT_EN
        check("miss_sat", miss_cnt, 8'd255);
`endif
        miss_clr = 1'b1; cycle(); miss_clr = 1'b0;
`ifdef SWITCH_SEQ_MISS_CNT_EN
        check("miss_clr", miss_cnt, 8'd0);
`endif
        run_until(3, "long_end"); run(4);

        // reset in the middle of the set pulse, then a fresh sequence with new cfg
        set_cfg(1, 10, 3); pulse_trig(); run_until(0, "reach_set2"); run(2);
        do_reset();
        set_cfg(2, 3, 2); pulse_trig(); run(16);

        // cfg change during delay must not affect the running sequence
        set_cfg(5, 2, 5); pulse_trig(); cycle();
        cfg_hold = CNT_W'(1); cfg_width = CNT_W'(7); run(20);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            trig     = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 19) == 0);
            miss_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end
        trig = 1'b0; abort = 1'b0; miss_clr = 1'b0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
